// File: rtl/baccarat_tally.sv
// rtl/baccarat_tally.sv - match scoreboard for the baccarat round state machine
// Counts each END result once, tracks streaks and declares a winner at TARGET wins.
module baccarat_tally #(
   parameter int CW     = 8,
   parameter int TARGET = 5
) (
   input  logic          slow_clock,
   input  logic          resetb,
   input  logic          player_win_light,
   input  logic          dealer_win_light,
   input  logic          new_match,
   output logic [CW-1:0] player_wins,
   output logic [CW-1:0] dealer_wins,
   output logic [CW-1:0] ties,
   output logic [CW-1:0] rounds,
   output logic [1:0]    streak_owner,
   output logic [CW-1:0] streak_len,
   output logic [CW-1:0] longest_streak,
   output logic          match_over,
   output logic [1:0]    match_winner
);

   typedef enum logic [1:0] {ARMED, HELD, OVER} state_t;

   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] TGT = CW'(TARGET);
   localparam logic [1:0]    OWN_PLAYER = 2'b10;
   localparam logic [1:0]    OWN_DEALER = 2'b01;

   state_t        state, state_nx;
   logic [1:0]    r;
   logic [CW-1:0] player_wins_nx, dealer_wins_nx, ties_nx, rounds_nx;
   logic [CW-1:0] streak_len_nx, longest_nx;
   logic [1:0]    streak_owner_nx, match_winner_nx;
   logic          match_over_nx;

   assign r = {player_win_light, dealer_win_light};

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction

   always_ff @(negedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         state          <= ARMED;
         player_wins    <= '0;
         dealer_wins    <= '0;
         ties           <= '0;
         rounds         <= '0;
         streak_owner   <= 2'b00;
         streak_len     <= '0;
         longest_streak <= '0;
         match_over     <= 1'b0;
         match_winner   <= 2'b00;
      end else begin
         state          <= state_nx;
         player_wins    <= player_wins_nx;
         dealer_wins    <= dealer_wins_nx;
         ties           <= ties_nx;
         rounds         <= rounds_nx;
         streak_owner   <= streak_owner_nx;
         streak_len     <= streak_len_nx;
         longest_streak <= longest_nx;
         match_over     <= match_over_nx;
         match_winner   <= match_winner_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      player_wins_nx  = player_wins;
      dealer_wins_nx  = dealer_wins;
      ties_nx         = ties;
      rounds_nx       = rounds;
      streak_owner_nx = streak_owner;
      streak_len_nx   = streak_len;
      longest_nx      = longest_streak;
      match_over_nx   = match_over;
      match_winner_nx = match_winner;

      if (new_match) begin
         // A result already on the lights belongs to no match; wait for it to drop.
         state_nx        = (r != 2'b00) ? HELD : ARMED;
         player_wins_nx  = '0;
         dealer_wins_nx  = '0;
         ties_nx         = '0;
         rounds_nx       = '0;
         streak_owner_nx = 2'b00;
         streak_len_nx   = '0;
         longest_nx      = '0;
         match_over_nx   = 1'b0;
         match_winner_nx = 2'b00;
      end else begin
         case (state)
            ARMED: begin
               if (r != 2'b00) begin
                  state_nx  = HELD;
                  rounds_nx = sat_inc(rounds);
                  case (r)
                     2'b10: begin
                        player_wins_nx = sat_inc(player_wins);
                        if (streak_owner == OWN_PLAYER) begin
                           streak_len_nx = sat_inc(streak_len);
                        end else begin
                           streak_owner_nx = OWN_PLAYER;
                           streak_len_nx   = ONE;
                        end
                        if (player_wins_nx == TGT) begin
                           state_nx        = OVER;
                           match_over_nx   = 1'b1;
                           match_winner_nx = OWN_PLAYER;
                        end
                     end
                     2'b01: begin
                        dealer_wins_nx = sat_inc(dealer_wins);
                        if (streak_owner == OWN_DEALER) begin
                           streak_len_nx = sat_inc(streak_len);
                        end else begin
                           streak_owner_nx = OWN_DEALER;
                           streak_len_nx   = ONE;
                        end
                        if (dealer_wins_nx == TGT) begin
                           state_nx        = OVER;
                           match_over_nx   = 1'b1;
                           match_winner_nx = OWN_DEALER;
                        end
                     end
                     default: begin
                        ties_nx         = sat_inc(ties);
                        streak_owner_nx = 2'b00;
                        streak_len_nx   = '0;
                     end
                  endcase
                  if (streak_len_nx > longest_streak) longest_nx = streak_len_nx;
               end
            end
            HELD: begin
               if (r == 2'b00) state_nx = ARMED;
            end
            default: begin
               state_nx = OVER;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_baccarat_tally.sv
// tb/tb_baccarat_tally.sv - self-checking bench for baccarat_tally
// Two instances (CW=8/TARGET=5 and CW=3/TARGET=7) share stimulus and are checked against a model.
module tb_baccarat_tally;

   logic slow_clock = 1'b1;
   logic resetb = 1'b0;
   logic pl = 1'b0, dl = 1'b0, new_match = 1'b0;
   logic chk_en = 1'b0;

   logic [7:0] a_pw, a_dw, a_ti, a_rd, a_len, a_lng;
   logic [1:0] a_own, a_win;
   logic       a_over;
   logic [2:0] b_pw, b_dw, b_ti, b_rd, b_len, b_lng;
   logic [1:0] b_own, b_win;
   logic       b_over;

   int errors = 0;
   int checks = 0;

   int cap [2] = '{255, 7};
   int tgt [2] = '{5, 7};
   int m_pw [2], m_dw [2], m_ti [2], m_rd [2], m_own [2], m_len [2], m_lng [2], m_over [2], m_win [2];
   bit m_wait [2];

   always #5 slow_clock = ~slow_clock;

   baccarat_tally #(.CW(8), .TARGET(5)) dut_a (
      .slow_clock(slow_clock), .resetb(resetb), .player_win_light(pl), .dealer_win_light(dl),
      .new_match(new_match), .player_wins(a_pw), .dealer_wins(a_dw), .ties(a_ti), .rounds(a_rd),
      .streak_owner(a_own), .streak_len(a_len), .longest_streak(a_lng), .match_over(a_over),
      .match_winner(a_win));

   baccarat_tally #(.CW(3), .TARGET(7)) dut_b (
      .slow_clock(slow_clock), .resetb(resetb), .player_win_light(pl), .dealer_win_light(dl),
      .new_match(new_match), .player_wins(b_pw), .dealer_wins(b_dw), .ties(b_ti), .rounds(b_rd),
      .streak_owner(b_own), .streak_len(b_len), .longest_streak(b_lng), .match_over(b_over),
      .match_winner(b_win));

   function automatic int inc(input int v, input int c);
      return (v >= c) ? c : v + 1;
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: rules as plain integer arithmetic.
   always @(negedge slow_clock or negedge resetb) begin
      for (int i = 0; i < 2; i++) begin
         if (!resetb || new_match) begin
            m_pw[i] = 0; m_dw[i] = 0; m_ti[i] = 0; m_rd[i] = 0;
            m_own[i] = 0; m_len[i] = 0; m_lng[i] = 0; m_over[i] = 0; m_win[i] = 0;
            m_wait[i] = resetb && (pl || dl);
         end else if (m_over[i] == 0 && !m_wait[i] && (pl || dl)) begin
            m_wait[i] = 1'b1;
            m_rd[i] = inc(m_rd[i], cap[i]);
            if (pl && dl) begin
               m_ti[i] = inc(m_ti[i], cap[i]);
               m_own[i] = 0;
               m_len[i] = 0;
            end else if (pl) begin
               m_pw[i] = inc(m_pw[i], cap[i]);
               m_len[i] = (m_own[i] == 2) ? inc(m_len[i], cap[i]) : 1;
               m_own[i] = 2;
               if (m_pw[i] == tgt[i]) begin m_over[i] = 1; m_win[i] = 2; end
            end else begin
               m_dw[i] = inc(m_dw[i], cap[i]);
               m_len[i] = (m_own[i] == 1) ? inc(m_len[i], cap[i]) : 1;
               m_own[i] = 1;
               if (m_dw[i] == tgt[i]) begin m_over[i] = 1; m_win[i] = 1; end
            end
            if (m_len[i] > m_lng[i]) m_lng[i] = m_len[i];
         end else if (!(pl || dl)) begin
            m_wait[i] = 1'b0;
         end
      end
   end

   always @(posedge slow_clock) begin
      if (chk_en) begin
         cmp("a.player_wins", a_pw, m_pw[0]);   cmp("b.player_wins", b_pw, m_pw[1]);
         cmp("a.dealer_wins", a_dw, m_dw[0]);   cmp("b.dealer_wins", b_dw, m_dw[1]);
         cmp("a.ties", a_ti, m_ti[0]);          cmp("b.ties", b_ti, m_ti[1]);
         cmp("a.rounds", a_rd, m_rd[0]);        cmp("b.rounds", b_rd, m_rd[1]);
         cmp("a.streak_owner", a_own, m_own[0]); cmp("b.streak_owner", b_own, m_own[1]);
         cmp("a.streak_len", a_len, m_len[0]);  cmp("b.streak_len", b_len, m_len[1]);
         cmp("a.longest", a_lng, m_lng[0]);     cmp("b.longest", b_lng, m_lng[1]);
         cmp("a.match_over", a_over, m_over[0]); cmp("b.match_over", b_over, m_over[1]);
         cmp("a.match_winner", a_win, m_win[0]); cmp("b.match_winner", b_win, m_win[1]);
      end
   end

   task automatic round(input logic [1:0] rr);
      @(posedge slow_clock); {pl, dl} = rr;
      @(posedge slow_clock); {pl, dl} = 2'b00;
      repeat (4) @(posedge slow_clock);
      #1;
   endtask

   task automatic clear_match();
      @(posedge slow_clock); new_match = 1'b1;
      @(posedge slow_clock); new_match = 1'b0;
      @(posedge slow_clock); #1;
   endtask

   initial begin
      #1;
      cmp("reset a.player_wins", a_pw, 0);
      cmp("reset a.match_winner", a_win, 0);
      cmp("reset b.rounds", b_rd, 0);
      @(posedge slow_clock); @(posedge slow_clock);
      resetb = 1'b1;
      chk_en = 1'b1;

      repeat (3) round(2'b10);
      cmp("t1 player_wins", a_pw, 3);
      cmp("t1 rounds", a_rd, 3);
      cmp("t1 streak_owner", a_own, 2);
      cmp("t1 streak_len", a_len, 3);
      cmp("t1 longest", a_lng, 3);

      clear_match();
      round(2'b10); round(2'b10); round(2'b11);
      round(2'b01); round(2'b01); round(2'b01);
      cmp("t2 player_wins", a_pw, 2);
      cmp("t2 dealer_wins", a_dw, 3);
      cmp("t2 ties", a_ti, 1);
      cmp("t2 rounds", a_rd, 6);
      cmp("t2 streak_owner", a_own, 1);
      cmp("t2 streak_len", a_len, 3);
      cmp("t2 longest", a_lng, 3);

      clear_match();
      @(posedge slow_clock); {pl, dl} = 2'b10;
      repeat (4) @(posedge slow_clock);
      {pl, dl} = 2'b01;
      repeat (2) @(posedge slow_clock);
      {pl, dl} = 2'b00;
      repeat (2) @(posedge slow_clock); #1;
      cmp("t3 held player_wins", a_pw, 1);
      cmp("t3 held dealer_wins", a_dw, 0);
      cmp("t3 held rounds", a_rd, 1);

      clear_match();
      repeat (5) round(2'b01);
      cmp("t4 match_over", a_over, 1);
      cmp("t4 match_winner", a_win, 1);
      cmp("t4 dealer_wins", a_dw, 5);
      round(2'b10);
      cmp("t4 frozen player_wins", a_pw, 0);
      cmp("t4 frozen rounds", a_rd, 5);
      cmp("t4 b not over", b_over, 0);

      @(posedge slow_clock); new_match = 1'b1; {pl, dl} = 2'b10;
      @(posedge slow_clock);
      @(posedge slow_clock); new_match = 1'b0;
      @(posedge slow_clock); {pl, dl} = 2'b00;
      @(posedge slow_clock); #1;
      cmp("t5 discarded player_wins", a_pw, 0);
      cmp("t5 cleared match_over", a_over, 0);
      cmp("t5 cleared dealer_wins", a_dw, 0);
      round(2'b10);
      cmp("t5 clean player_wins", a_pw, 1);

      clear_match();
      repeat (10) round(2'b11);
      cmp("t6 b.ties saturate", b_ti, 7);
      cmp("t6 b.rounds saturate", b_rd, 7);
      cmp("t6 b.match_over", b_over, 0);
      cmp("t6 a.ties", a_ti, 10);
      @(posedge slow_clock); {pl, dl} = 2'b11;
      #2 resetb = 1'b0;
      #1;
      cmp("t6 async a.ties", a_ti, 0);
      cmp("t6 async a.rounds", a_rd, 0);
      cmp("t6 async b.ties", b_ti, 0);
      cmp("t6 async b.rounds", b_rd, 0);
      #1 resetb = 1'b1;
      @(posedge slow_clock); {pl, dl} = 2'b00;
      repeat (3) @(posedge slow_clock); #1;
      cmp("t6 after reset b.ties", b_ti, 1);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/baccarat_tally.md
# baccarat_tally

Match scoreboard that sits directly downstream of the baccarat round state machine and consumes its `player_win_light` / `dealer_win_light` outputs. It detects each completed round and keeps saturating tallies of player wins, dealer wins, ties and total rounds. It also tracks the current and longest win streak, and declares a match winner when either side first reaches a target number of wins. Tallies then freeze until a new match is requested or reset is applied.

## Interface
- `CW`, 8, width of every tally/streak counter; all counters saturate at 2^CW-1
- `TARGET`, 5, wins needed to take the match; must satisfy 1 ≤ TARGET ≤ 2^CW-1

- `slow_clock`  in  1  round clock; all state updates on its negedge (same edge as the round state machine)
- `resetb`  in  1  asynchronous, active-low reset
- `player_win_light`  in  1  from round state machine; high during END when player wins or ties
- `dealer_win_light`  in  1  from round state machine; high during END when dealer wins or ties
- `new_match`  in  1  synchronous request: clear tallies and start a new match
- `player_wins`  out  CW  player win count
- `dealer_wins`  out  CW  dealer win count
- `ties`  out  CW  tie count
- `rounds`  out  CW  total completed rounds (wins + ties)
- `streak_owner`  out  2  10 = player, 01 = dealer, 00 = none
- `streak_len`  out  CW  length of the current streak
- `longest_streak`  out  CW  maximum `streak_len` reached this match
- `match_over`  out  1  target reached; results ignored
- `match_winner`  out  2  10 = player, 01 = dealer, 00 = undecided

## Operation
- Result code `r = {player_win_light, dealer_win_light}`: 10 = player, 01 = dealer, 11 = tie, 00 = no result.
- FSM states:
  - ARMED: waiting for a result.
  - HELD: a result has been recorded; waiting for `r` to return to 00.
  - OVER: match finished.
- ARMED, `r != 00`:
  - Record the result and increment `rounds`.
  - Go to HELD, unless the result reaches TARGET, in which case go to OVER.
- HELD:
  - Stay while `r != 00`; go to ARMED when `r == 00`.
  - A long-held result is therefore counted exactly once.
- Recording a player result:
  - `player_wins += 1`.
  - If `streak_owner == 10`, `streak_len += 1`; otherwise `streak_owner <= 10` and `streak_len <= 1`.
  - `longest_streak <= max(longest_streak, new streak_len)`.
- Recording a dealer result: mirror of the player case, using `dealer_wins` and owner 01.
- Recording a tie: `ties += 1`, `streak_owner <= 00`, `streak_len <= 0`. Ties never end a match.
- Match end:
  - If the post-increment `player_wins == TARGET`, set `match_over <= 1`, `match_winner <= 10`, state ← OVER.
  - Dealer is analogous with 01.
- OVER: all outputs hold and `r` is ignored until `new_match` or reset.
- Saturation: any counter at 2^CW-1 holds its value; the other updates proceed normally.
- `new_match` at a negedge has priority over any result on the same edge. That result is discarded.
  - All counters, `streak_owner`, `match_over` and `match_winner` clear to 0.
  - State ← HELD if `r != 00`, else ARMED. A result already showing is not counted into the new match.

## Timing
- Reset (`resetb` low, asynchronous, effective immediately, including mid-round or in OVER):
  - state = ARMED.
  - All outputs 0: counters 0, `streak_owner` 00, `match_over` 0, `match_winner` 00.
- Inputs are sampled at the negedge of `slow_clock`.
- The round state machine holds END for exactly one period, so the lights are sampled at the negedge that ends END. Updated tallies are visible immediately after that same edge (zero additional cycles).
- Back-to-back rounds:
  - The RST→PC1→…→END sequence presents `r == 00` for ≥4 negedges between results.
  - Each END is counted once.
- `new_match` is level-sampled. Holding it high keeps the block cleared, and the block leaves the clear state on the first negedge with `new_match` low.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then three player results separated by `r = 00` → `player_wins = 3`, `rounds = 3`, `streak_owner = 10`, `streak_len = 3`, `longest_streak = 3`.
- Sequence P, P, T, D, D, D → `player_wins = 2`, `dealer_wins = 3`, `ties = 1`, `rounds = 6`, `streak_owner = 01`, `streak_len = 3`, `longest_streak = 3`.
- Hold `r = 10` for 4 negedges → counted once (`player_wins = 1`). Further results are ignored until `r` returns to 00.
- TARGET = 5, five dealer results → `match_over = 1`, `match_winner = 01`, `dealer_wins = 5`. A subsequent player result leaves all outputs unchanged.
- `new_match` asserted on the same edge as `r = 10` → all counters 0, that result not counted. Next clean P result → `player_wins = 1`.
- `CW = 3`, `TARGET = 7`, 10 tie results → `ties` saturates at 7, `rounds` saturates at 7, `match_over = 0`. `resetb` pulsed low mid-sequence → all outputs 0 immediately, without a clock edge.
